// File: rtl/dragon_body_trail.sv
// Dragon body history: a shift register of past head tiles, a renderer read port,
// and a per-move collision scan of the active segments against the player tile.
module dragon_body_trail #(
    parameter int MAX_LEN = 15,
    parameter int LOC_W   = 8
) (
    input  logic             frame_clk,
    input  logic             rst,
    input  logic             move_valid,
    output logic             move_ready,
    input  logic [LOC_W-1:0] head_location,
    input  logic [1:0]       head_direction,
    input  logic [3:0]       body_length,
    input  logic [LOC_W-1:0] player_location,
    input  logic             rd_req,
    input  logic [3:0]       rd_index,
    output logic             rd_valid,
    output logic [LOC_W-1:0] rd_location,
    output logic [1:0]       rd_direction,
    output logic             rd_active,
    output logic             player_hit,
    output logic             scan_done
);

    typedef enum logic [1:0] {IDLE, SHIFT, SCAN, DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'(MAX_LEN - 1);
    localparam logic [3:0] FULL_CNT = 4'(MAX_LEN);

    state_t           state, state_next;
    logic [LOC_W-1:0] seg_loc [MAX_LEN];
    logic [1:0]       seg_dir [MAX_LEN];
    logic [LOC_W-1:0] head_reg, pend_loc;
    logic [1:0]       head_dir_reg, pend_dir;
    logic [3:0]       filled, filled_inc, active, active_post, scan_k;
    logic             hit_latch;

    always_comb begin
        filled_inc  = (filled == FULL_CNT) ? filled : filled + 4'd1;
        active      = (filled < body_length) ? filled : body_length;
        active_post = (filled_inc < body_length) ? filled_inc : body_length;
        move_ready  = (state == IDLE);
        state_next  = state;
        case (state)
            IDLE:  if (move_valid) state_next = SHIFT;
            SHIFT: state_next = (active_post == 4'd0) ? DONE : SCAN;
            SCAN: begin
                if (({1'b0, scan_k} + 5'd1 >= {1'b0, active}) || (scan_k == LAST_IDX))
                    state_next = DONE;
            end
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // The accepted move waits in pend_* so SHIFT can push the previous head into seg[0].
    always_ff @(posedge frame_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_loc[i] <= '0;
                seg_dir[i] <= 2'd0;
            end
            head_reg     <= '0;
            head_dir_reg <= 2'd0;
            pend_loc     <= '0;
            pend_dir     <= 2'd0;
            filled       <= 4'd0;
            scan_k       <= 4'd0;
            hit_latch    <= 1'b0;
            player_hit   <= 1'b0;
            scan_done    <= 1'b0;
        end else begin
            scan_done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (move_valid) begin
                        pend_loc <= head_location;
                        pend_dir <= head_direction;
                    end
                end
                SHIFT: begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        seg_loc[i] <= seg_loc[i-1];
                        seg_dir[i] <= seg_dir[i-1];
                    end
                    seg_loc[0]   <= head_reg;
                    seg_dir[0]   <= head_dir_reg;
                    head_reg     <= pend_loc;
                    head_dir_reg <= pend_dir;
                    filled       <= filled_inc;
                    scan_k       <= 4'd0;
                    hit_latch    <= 1'b0;
                end
                SCAN: begin
                    if ((seg_loc[scan_k] == player_location) && (scan_k < active))
                        hit_latch <= 1'b1;
                    scan_k <= scan_k + 4'd1;
                end
                DONE: player_hit <= hit_latch;
                default: ;
            endcase
        end
    end

    // Read port sees the array as it stood at the request edge, whatever the FSM is doing.
    always_ff @(posedge frame_clk or negedge rst) begin
        if (!rst) begin
            rd_valid     <= 1'b0;
            rd_location  <= '0;
            rd_direction <= 2'd0;
            rd_active    <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                if (rd_index < FULL_CNT) begin
                    rd_location  <= seg_loc[rd_index];
                    rd_direction <= seg_dir[rd_index];
                    rd_active    <= (rd_index < active);
                end else begin
                    rd_location  <= '0;
                    rd_direction <= 2'd0;
                    rd_active    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dragon_body_trail.sv
// Self-checking bench for dragon_body_trail: scenario tasks plus randomized moves
// checked against a head-history queue model.
module tb_dragon_body_trail;

    logic       frame_clk = 1'b0;
    logic       rst;
    logic       move_valid;
    logic       move_ready;
    logic [7:0] head_location;
    logic [1:0] head_direction;
    logic [3:0] body_length;
    logic [7:0] player_location;
    logic       rd_req;
    logic [3:0] rd_index;
    logic       rd_valid;
    logic [7:0] rd_location;
    logic [1:0] rd_direction;
    logic       rd_active;
    logic       player_hit;
    logic       scan_done;

    int checks = 0;
    int passed = 0;

    // Every head ever taken, oldest first; entry 0 is the reset head (tile 0, UP).
    logic [7:0] hist_loc [$];
    logic [1:0] hist_dir [$];

    always #5 frame_clk = ~frame_clk;

    dragon_body_trail dut (
        .frame_clk       (frame_clk),
        .rst             (rst),
        .move_valid      (move_valid),
        .move_ready      (move_ready),
        .head_location   (head_location),
        .head_direction  (head_direction),
        .body_length     (body_length),
        .player_location (player_location),
        .rd_req          (rd_req),
        .rd_index        (rd_index),
        .rd_valid        (rd_valid),
        .rd_location     (rd_location),
        .rd_direction    (rd_direction),
        .rd_active       (rd_active),
        .player_hit      (player_hit),
        .scan_done       (scan_done)
    );

    function automatic void model_reset();
        hist_loc.delete();
        hist_dir.delete();
        hist_loc.push_back(8'h00);
        hist_dir.push_back(2'd0);
    endfunction

    // Segment k is the head from k+1 moves ago; older than history means reset contents.
    function automatic logic [7:0] m_seg_loc(int k);
        int j = hist_loc.size() - 2 - k;
        if (k >= 15 || j < 0) return 8'h00;
        return hist_loc[j];
    endfunction

    function automatic logic [1:0] m_seg_dir(int k);
        int j = hist_dir.size() - 2 - k;
        if (k >= 15 || j < 0) return 2'd0;
        return hist_dir[j];
    endfunction

    function automatic int m_active(int len);
        int moves = hist_loc.size() - 1;
        int fill  = (moves > 15) ? 15 : moves;
        return (fill < len) ? fill : len;
    endfunction

    function automatic logic m_hit(int len, logic [7:0] ploc);
        for (int k = 0; k < m_active(len); k++)
            if (m_seg_loc(k) == ploc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic apply_reset();
        @(negedge frame_clk);
        rst = 1'b0;
        @(negedge frame_clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic do_move(input logic [7:0] loc, input logic [1:0] dir,
                           output int lat, output logic done_seen, output logic hit);
        @(negedge frame_clk);
        move_valid     = 1'b1;
        head_location  = loc;
        head_direction = dir;
        @(negedge frame_clk);
        move_valid = 1'b0;
        lat = 0;
        while (!move_ready && lat < 40) begin
            lat++;
            @(negedge frame_clk);
        end
        done_seen = scan_done;
        hit       = player_hit;
        hist_loc.push_back(loc);
        hist_dir.push_back(dir);
    endtask

    task automatic read_seg(input logic [3:0] idx, output logic v, output logic [7:0] loc,
                            output logic [1:0] dir, output logic act);
        @(negedge frame_clk);
        rd_req   = 1'b1;
        rd_index = idx;
        @(negedge frame_clk);
        rd_req = 1'b0;
        v   = rd_valid;
        loc = rd_location;
        dir = rd_direction;
        act = rd_active;
    endtask

    task automatic test_reset();
        logic v, act;
        logic [7:0] loc;
        logic [1:0] dir;
        @(negedge frame_clk);
        rst = 1'b0;
        #1;
        checks++;
        if (move_ready !== 1'b1) $display("[TB] FAIL reset_move_ready got=%b want=1", move_ready);
        else passed++;
        checks++;
        if ({player_hit, scan_done, rd_valid} !== 3'b000)
            $display("[TB] FAIL reset_outputs hit/done/valid got=%b want=000", {player_hit, scan_done, rd_valid});
        else passed++;
        @(negedge frame_clk);
        rst = 1'b1;
        model_reset();
        read_seg(4'd0, v, loc, dir, act);
        checks++;
        if ({v, act} !== 2'b10) $display("[TB] FAIL reset_rd0 valid/active got=%b want=10", {v, act});
        else passed++;
    endtask

    task automatic test_moves();
        int lat;
        logic done, hit, v, act;
        logic [7:0] loc;
        logic [1:0] dir;
        logic [7:0] want_loc [4] = '{8'h12, 8'h11, 8'h00, 8'h00};
        logic       want_act [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        body_length     = 4'd4;
        player_location = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            do_move(8'h11 + 8'(i), 2'd1, lat, done, hit);
            checks++;
            if (lat !== i + 3 || done !== 1'b1 || hit !== 1'b0)
                $display("[TB] FAIL move%0d lat/done/hit got=%0d/%b/%b want=%0d/1/0", i, lat, done, hit, i + 3);
            else passed++;
        end
        for (int k = 0; k < 4; k++) begin
            read_seg(4'(k), v, loc, dir, act);
            checks++;
            if (v !== 1'b1 || loc !== want_loc[k] || act !== want_act[k] || dir !== m_seg_dir(k))
                $display("[TB] FAIL moves_seg%0d v/loc/dir/act got=%b/%h/%0d/%b want=1/%h/%0d/%b",
                         k, v, loc, dir, act, want_loc[k], m_seg_dir(k), want_act[k]);
            else passed++;
        end
    endtask

    task automatic test_collision();
        int lat;
        logic done, hit;
        player_location = 8'h11;
        do_move(8'h14, 2'd1, lat, done, hit);
        checks++;
        if (lat !== 6 || done !== 1'b1 || hit !== 1'b1 || m_hit(4, 8'h11) !== 1'b1)
            $display("[TB] FAIL collision lat/done/hit got=%0d/%b/%b want=6/1/1", lat, done, hit);
        else passed++;
        @(negedge frame_clk);
        checks++;
        if (scan_done !== 1'b0 || player_hit !== 1'b1)
            $display("[TB] FAIL collision_hold done/hit got=%b/%b want=0/1", scan_done, player_hit);
        else passed++;
    endtask

    task automatic test_shrink_regrow();
        int lat;
        logic done, hit, v, act;
        logic [7:0] loc;
        logic [1:0] dir;
        logic [4:0] got;
        apply_reset();
        body_length     = 4'd5;
        player_location = 8'hEE;
        for (int i = 0; i < 6; i++)
            do_move(8'($urandom_range(0, 8'hED)), 2'($urandom), lat, done, hit);
        body_length = 4'd2;
        for (int k = 0; k < 5; k++) begin
            read_seg(4'(k), v, loc, dir, act);
            got[k] = act;
        end
        checks++;
        if (got !== 5'b00011) $display("[TB] FAIL shrink_active got=%b want=00011", got);
        else passed++;
        body_length = 4'd5;
        for (int k = 0; k < 5; k++) begin
            read_seg(4'(k), v, loc, dir, act);
            got[k] = act;
            checks++;
            if (loc !== m_seg_loc(k))
                $display("[TB] FAIL regrow_loc%0d got=%h want=%h", k, loc, m_seg_loc(k));
            else passed++;
        end
        checks++;
        if (got !== 5'b11111) $display("[TB] FAIL regrow_active got=%b want=11111", got);
        else passed++;
    endtask

    task automatic test_random();
        int lat, len;
        logic done, hit, v, act;
        logic [7:0] loc, ploc;
        logic [1:0] dir;
        logic [3:0] idx;
        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(0, 15);
            body_length = 4'(len);
            if ($urandom_range(0, 1) == 1) ploc = hist_loc[$urandom_range(0, hist_loc.size() - 1)];
            else ploc = 8'($urandom);
            player_location = ploc;
            do_move(8'($urandom), 2'($urandom), lat, done, hit);
            checks++;
            if (lat !== m_active(len) + 2 || done !== 1'b1 || hit !== m_hit(len, ploc))
                $display("[TB] FAIL rand_move%0d lat/done/hit got=%0d/%b/%b want=%0d/1/%b",
                         n, lat, done, hit, m_active(len) + 2, m_hit(len, ploc));
            else passed++;
            idx = 4'($urandom_range(0, 15));
            read_seg(idx, v, loc, dir, act);
            checks++;
            if (v !== 1'b1 || loc !== m_seg_loc(idx) || dir !== m_seg_dir(idx) || act !== (int'(idx) < m_active(len)))
                $display("[TB] FAIL rand_read%0d idx=%0d loc/dir/act got=%h/%0d/%b want=%h/%0d/%b",
                         n, idx, loc, dir, act, m_seg_loc(idx), m_seg_dir(idx), int'(idx) < m_active(len));
            else passed++;
        end
    endtask

    task automatic test_edges();
        int lat;
        logic v, act;
        logic [7:0] loc, exp_loc, new_loc;
        logic [1:0] dir, exp_dir;
        logic exp_act;
        body_length = 4'd15;
        read_seg(4'd15, v, loc, dir, act);
        checks++;
        if ({v, act, loc} !== {2'b10, 8'h00})
            $display("[TB] FAIL idx15 valid/active/loc got=%b/%b/%h want=1/0/00", v, act, loc);
        else passed++;
        exp_loc = m_seg_loc(0);
        exp_dir = m_seg_dir(0);
        exp_act = (m_active(15) > 0);
        new_loc = 8'($urandom);
        @(negedge frame_clk);
        move_valid    = 1'b1;
        head_location = new_loc;
        @(negedge frame_clk);
        move_valid = 1'b0;
        rd_req     = 1'b1;
        rd_index   = 4'd0;
        @(negedge frame_clk);
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_location !== exp_loc || rd_direction !== exp_dir || rd_active !== exp_act)
            $display("[TB] FAIL shift_read v/loc/dir/act got=%b/%h/%0d/%b want=1/%h/%0d/%b",
                     rd_valid, rd_location, rd_direction, rd_active, exp_loc, exp_dir, exp_act);
        else passed++;
        lat = 0;
        while (!move_ready && lat < 40) begin
            lat++;
            @(negedge frame_clk);
        end
        hist_loc.push_back(new_loc);
        hist_dir.push_back(head_direction);
        checks++;
        if (lat >= 40) $display("[TB] FAIL shift_read_timeout cycles=%0d limit=40", lat);
        else passed++;
        read_seg(4'd0, v, loc, dir, act);
        checks++;
        if (loc !== m_seg_loc(0)) $display("[TB] FAIL post_shift_seg0 got=%h want=%h", loc, m_seg_loc(0));
        else passed++;
    endtask

    task automatic test_reset_mid_scan();
        int lat, dones;
        logic done, hit, v, act;
        logic [7:0] loc;
        logic [1:0] dir;
        apply_reset();
        body_length     = 4'd15;
        player_location = 8'hEE;
        for (int i = 0; i < 4; i++) do_move(8'($urandom_range(1, 8'hED)), 2'd2, lat, done, hit);
        @(negedge frame_clk);
        move_valid    = 1'b1;
        head_location = 8'h33;
        @(negedge frame_clk);
        move_valid = 1'b0;
        @(negedge frame_clk);
        @(negedge frame_clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({move_ready, scan_done, player_hit} !== 3'b100)
            $display("[TB] FAIL midscan_reset ready/done/hit got=%b want=100", {move_ready, scan_done, player_hit});
        else passed++;
        @(negedge frame_clk);
        rst = 1'b1;
        model_reset();
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge frame_clk);
            if (scan_done) dones++;
        end
        checks++;
        if (dones !== 0) $display("[TB] FAIL midscan_no_done got=%0d want=0", dones);
        else passed++;
        for (int k = 0; k < 5; k++) begin
            read_seg(4'(k), v, loc, dir, act);
            checks++;
            if ({act, loc} !== {1'b0, 8'h00})
                $display("[TB] FAIL midscan_seg%0d active/loc got=%b/%h want=0/00", k, act, loc);
            else passed++;
        end
    endtask

    initial begin
        rst             = 1'b1;
        move_valid      = 1'b0;
        head_location   = 8'h00;
        head_direction  = 2'd0;
        body_length     = 4'd0;
        player_location = 8'h00;
        rd_req          = 1'b0;
        rd_index        = 4'd0;
        model_reset();
        test_reset();
        test_moves();
        test_collision();
        test_shrink_regrow();
        test_random();
        test_edges();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
